l2_cacheline_adaptor: RTL and testbench



---
 rtl/l2_cacheline_adaptor.sv | 106 ++++++++++
 tb/tb_l2_cacheline_adaptor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/l2_cacheline_adaptor.sv
// Converts 256-bit L2 line fills and write-backs into 4-beat 64-bit memory bursts.
// The L2 control unit sees a single-cycle completion pulse on resp_o.
//
// state | meaning
// IDLE  | waiting for read_i / write_i, captures address (and line on write)
// RD    | read_o high, one beat stored per resp_i cycle
// WR    | write_o high, one beat presented per resp_i cycle
// DONE  | resp_o pulse to L2, back to IDLE next cycle
module l2_cacheline_adaptor #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = s_line / s_burst;
  localparam int CW    = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [s_line-1:0]  buf_q, buf_d;
  logic [31:0]        addr_q, addr_d;
  logic               last_beat;

  assign last_beat = (cnt_q == CW'(BEATS - 1));
  assign line_o    = buf_q;
  assign address_o = addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    case (state_q)
      IDLE: begin
        if (read_i) begin
          addr_d  = {address_i[31:s_offset], {s_offset{1'b0}}};
          cnt_d   = '0;
          state_d = RD;
        end else if (write_i) begin
          addr_d  = {address_i[31:s_offset], {s_offset{1'b0}}};
          buf_d   = line_i;
          cnt_d   = '0;
          state_d = WR;
        end
      end
      RD: begin
        read_o = 1'b1;
        if (resp_i) begin
          buf_d[cnt_q*s_burst +: s_burst] = burst_i;
          // counter parks on the last beat; only the IDLE capture clears it
          if (last_beat) state_d = DONE;
          else           cnt_d   = cnt_q + CW'(1);
        end
      end
      WR: begin
        write_o = 1'b1;
        burst_o = buf_q[cnt_q*s_burst +: s_burst];
        if (resp_i) begin
          if (last_beat) state_d = DONE;
          else           cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Randomized bench for l2_cacheline_adaptor: directed scenarios plus random
// fills/write-backs checked against a beat-level reference of the line transfer.
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int checks   = 0;
  int failures = 0;

  bit          ack_pat[$];
  bit          use_src = 1'b0;
  logic [63:0] src[4];
  int          stall_pct = 0;

  l2_cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left in an IDLE cycle, one time unit after the clock edge.
  task automatic do_xfer(input bit is_read, input logic [31:0] addr,
                         input logic [255:0] wline, input bit hold_write);
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;
    int           done;
    int           cyc;
    bit           ack;
    exp_addr  = {addr[31:5], 5'b0};
    exp_line  = is_read ? 256'd0 : wline;
    address_i = addr;
    line_i    = wline;
    read_i    = is_read;
    write_i   = !is_read || hold_write;
    resp_i    = 1'b0;
    check("idle_outputs", {read_o, write_o, resp_o}, 3'b000);
    done = 0;
    cyc  = 0;
    while (done < 4 && cyc < 100) begin
      step();
      cyc++;
      check("read_o", read_o, is_read);
      check("write_o", write_o, !is_read);
      check("resp_early", resp_o, 1'b0);
      check("address_o", address_o, exp_addr);
      if (!is_read) check("burst_o", burst_o, wline[done*64 +: 64]);
      address_i = $urandom;
      line_i    = {8{$urandom}};
      if (ack_pat.size() > 0) ack = ack_pat.pop_front();
      else                    ack = ($urandom_range(99) >= stall_pct);
      resp_i = ack;
      if (ack && use_src) burst_i = src[done];
      else                burst_i = {$urandom, $urandom};
      if (ack) begin
        if (is_read) exp_line[done*64 +: 64] = burst_i;
        done++;
      end
    end
    check("beats_acked", done, 4);
    step();
    resp_i  = 1'b0;
    burst_i = {$urandom, $urandom};
    check("resp_o", resp_o, 1'b1);
    check("done_rw_low", {read_o, write_o}, 2'b00);
    check("line_o", line_o, exp_line);
    check("address_done", address_o, exp_addr);
    read_i  = 1'b0;
    write_i = hold_write;
    step();
    check("resp_single", resp_o, 1'b0);
    check("after_rw_low", {read_o, write_o}, 2'b00);
  endtask

  initial begin
    logic [255:0] d;
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 0; write_i = 0;
    burst_i = '0; resp_i = 0;
    step(); step();
    check("rst_outputs", {read_o, write_o, resp_o}, 3'b000);
    check("rst_line_o", line_o, 256'd0);
    check("rst_address_o", address_o, 32'd0);
    check("rst_burst_o", burst_o, 64'd0);
    rst = 1'b0;
    step();

    // read, no stalls
    use_src = 1'b1;
    src[0] = 64'h1111_1111_1111_1111; src[1] = 64'h2222_2222_2222_2222;
    src[2] = 64'h3333_3333_3333_3333; src[3] = 64'h4444_4444_4444_4444;
    ack_pat = '{1, 1, 1, 1};
    do_xfer(1'b1, 32'h1234_567F, 256'd0, 1'b0);
    check("read_line_const", line_o,
          {src[3], src[2], src[1], src[0]});

    // write, no stalls
    d = {64'hDDDD_0003_3333_3333, 64'hCCCC_0002_2222_2222,
         64'hBBBB_0001_1111_1111, 64'hAAAA_0000_0000_0000};
    ack_pat = '{1, 1, 1, 1};
    do_xfer(1'b0, 32'h0000_0040, d, 1'b0);

    // read with gaps 1,0,0,1,1,0,1
    src[0] = 64'h0123_4567_89AB_CDEF; src[1] = 64'hFEDC_BA98_7654_3210;
    src[2] = 64'h0F0F_0F0F_F0F0_F0F0; src[3] = 64'hA5A5_5A5A_C3C3_3C3C;
    ack_pat = '{1, 0, 0, 1, 1, 0, 1};
    do_xfer(1'b1, 32'h8000_1FFF, 256'd0, 1'b0);

    // simultaneous read and write: read first, write follows while still held
    use_src = 1'b0;
    ack_pat = '{1, 1, 1, 1};
    do_xfer(1'b1, 32'h0000_2020, 256'd0, 1'b1);
    ack_pat = '{1, 1, 1, 1};
    do_xfer(1'b0, 32'h0000_3030, {8{32'hCAFE_F00D}}, 1'b0);

    // reset after two beats of a read
    address_i = 32'h5555_AAAA; read_i = 1'b1;
    step();
    resp_i = 1'b1; burst_i = 64'h1;
    step();
    burst_i = 64'h2;
    step();
    check("pre_rst_read_o", read_o, 1'b1);
    rst = 1'b1; resp_i = 1'b0; read_i = 1'b0;
    step();
    check("mid_rst_rw", {read_o, write_o, resp_o}, 3'b000);
    check("mid_rst_line_o", line_o, 256'd0);
    check("mid_rst_address_o", address_o, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_resp", resp_o, 1'b0);
    ack_pat = '{1, 1, 0, 1, 1};
    do_xfer(1'b1, 32'h5555_AAAA, 256'd0, 1'b0);

    // spurious resp_i in IDLE
    resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("spurious_idle", {read_o, write_o, resp_o}, 3'b000);
    end
    resp_i = 1'b0;
    ack_pat = '{1, 1, 1, 1};
    do_xfer(1'b0, 32'h0000_0100, {8{32'h1357_9BDF}}, 1'b0);

    // random traffic
    stall_pct = 35;
    for (int n = 0; n < 24; n++) begin
      do_xfer(1'($urandom_range(1)), $urandom, {8{$urandom}}, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
